// File: rtl/rx_pkg.sv
// Shared constants and types for the receive-side FFT-shift reorder block.
package rx_pkg;

  localparam int FFT_LOG2 = 8;
  localparam int N        = 2 ** FFT_LOG2;
  localparam int DATA_W   = 12;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
  } iq_t;

  typedef enum logic {
    WR_WAIT_SOP = 1'b0,
    WR_FILL     = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/rx_fftshift_if.sv
// Sample stream into and out of the FFT-shift block; master is the FFT side, slave the reorder block.
interface rx_fftshift_if #(
  parameter int DATA_W = rx_pkg::DATA_W
);
  logic                     in_valid;
  logic                     in_sop;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] in_q;
  logic                     out_valid;
  logic                     out_sop;
  logic                     out_eop;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     frame_drop;

  modport master (
    output in_valid, in_sop, in_i, in_q,
    input  out_valid, out_sop, out_eop, out_i, out_q, frame_drop
  );

  modport slave (
    input  in_valid, in_sop, in_i, in_q,
    output out_valid, out_sop, out_eop, out_i, out_q, frame_drop
  );
endinterface

// File: rtl/rx_fftshift_ram.sv
// Simple dual-port frame store: one write port, one registered read port, no reset.
module rx_fftshift_ram #(
  parameter int AW = 9,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/rx_fftshift.sv
// Ping-pong frame buffer that replays each N-bin FFT frame with its halves swapped (DC to centre).
module rx_fftshift
  import rx_pkg::*;
#(
  parameter int FFT_LOG2 = rx_pkg::FFT_LOG2,
  parameter int DATA_W   = rx_pkg::DATA_W
) (
  input logic         clk,
  input logic         rst,
  rx_fftshift_if.slave bus
);
  localparam int AW = FFT_LOG2 + 1;
  localparam logic [FFT_LOG2-1:0] C_ONE  = FFT_LOG2'(1);
  localparam logic [FFT_LOG2-1:0] C_LAST = FFT_LOG2'((2 ** FFT_LOG2) - 1);
  localparam logic [FFT_LOG2-1:0] C_HALF = FFT_LOG2'(2 ** (FFT_LOG2 - 1));

  wr_state_e             r_wr_state, w_wr_state_nxt;
  logic [FFT_LOG2-1:0]   r_wr_cnt, w_wr_cnt_nxt, w_wr_idx;
  logic                  r_wr_bank, w_wr_bank_nxt;
  logic                  w_we, w_rd_start, w_drop;

  rd_state_e             r_rd_state, w_rd_state_nxt;
  logic [FFT_LOG2-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic                  r_rd_bank, w_rd_bank_nxt;
  logic                  w_rd_en;

  logic                  r_rd_v, r_rd_sop, r_rd_eop;
  logic [2*DATA_W-1:0]   w_rdata;
  logic                  r_out_valid, r_out_sop, r_out_eop, r_frame_drop;
  logic signed [DATA_W-1:0] r_out_i, r_out_q;

  rx_fftshift_ram #(.AW(AW), .DW(2 * DATA_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata ({bus.in_i, bus.in_q}),
    .i_raddr ({r_rd_bank, r_rd_cnt ^ C_HALF}),
    .o_rdata (w_rdata)
  );

  // Writer: an sop inside a partly filled frame restarts it at bin 0 in the same bank.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_bank_nxt  = r_wr_bank;
    w_wr_idx       = r_wr_cnt;
    w_we           = 1'b0;
    w_rd_start     = 1'b0;
    w_drop         = 1'b0;
    case (r_wr_state)
      WR_WAIT_SOP: begin
        if (bus.in_valid && bus.in_sop) begin
          w_we           = 1'b1;
          w_wr_idx       = '0;
          w_wr_cnt_nxt   = C_ONE;
          w_wr_state_nxt = WR_FILL;
        end else begin
          w_wr_cnt_nxt = '0;
        end
      end
      WR_FILL: begin
        if (!bus.in_valid) begin
          w_we = 1'b0;
        end else if (bus.in_sop) begin
          w_we         = 1'b1;
          w_wr_idx     = '0;
          w_wr_cnt_nxt = C_ONE;
          w_drop       = (r_wr_cnt != '0);
        end else if (r_wr_cnt == C_LAST) begin
          w_we           = 1'b1;
          w_wr_cnt_nxt   = '0;
          w_wr_bank_nxt  = ~r_wr_bank;
          w_rd_start     = 1'b1;
          w_wr_state_nxt = WR_WAIT_SOP;
        end else begin
          w_we         = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + C_ONE;
        end
      end
      default: begin
        w_wr_state_nxt = WR_WAIT_SOP;
        w_wr_cnt_nxt   = '0;
      end
    endcase
  end

  // Reader: a start landing on the final read chains straight into the next frame.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_bank_nxt  = r_rd_bank;
    w_rd_en        = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_rd_start) begin
          w_rd_state_nxt = RD_READ;
          w_rd_cnt_nxt   = '0;
          w_rd_bank_nxt  = r_wr_bank;
        end else begin
          w_rd_cnt_nxt = '0;
        end
      end
      RD_READ: begin
        w_rd_en = 1'b1;
        if (r_rd_cnt != C_LAST) begin
          w_rd_cnt_nxt = r_rd_cnt + C_ONE;
        end else if (w_rd_start) begin
          w_rd_cnt_nxt  = '0;
          w_rd_bank_nxt = r_wr_bank;
        end else begin
          w_rd_cnt_nxt   = '0;
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: begin
        w_rd_state_nxt = RD_IDLE;
        w_rd_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= WR_WAIT_SOP;
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
    end
  end

  // Flags ride alongside the one-cycle RAM read, then everything lands in the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v       <= 1'b0;
      r_rd_sop     <= 1'b0;
      r_rd_eop     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_i      <= '0;
      r_out_q      <= '0;
      r_frame_drop <= 1'b0;
    end else begin
      r_rd_v       <= w_rd_en;
      r_rd_sop     <= w_rd_en && (r_rd_cnt == '0);
      r_rd_eop     <= w_rd_en && (r_rd_cnt == C_LAST);
      r_out_valid  <= r_rd_v;
      r_out_sop    <= r_rd_sop;
      r_out_eop    <= r_rd_eop;
      r_out_i      <= r_rd_v ? w_rdata[2*DATA_W-1:DATA_W] : '0;
      r_out_q      <= r_rd_v ? w_rdata[DATA_W-1:0] : '0;
      r_frame_drop <= w_drop;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_sop    = r_out_sop;
  assign bus.out_eop    = r_out_eop;
  assign bus.out_i      = r_out_i;
  assign bus.out_q      = r_out_q;
  assign bus.frame_drop = r_frame_drop;
endmodule

// File: tb/tb_rx_fftshift.sv
// Randomized bench for rx_fftshift (N = 8) against a frame-level half-swap model.
module tb_rx_fftshift;
  localparam int LOG2 = 3;
  localparam int NB   = 8;
  localparam int DW   = 12;

  typedef struct {
    int i;
    int q;
    bit sop;
    bit eop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_fftshift_if #(.DATA_W(DW)) bus ();

  rx_fftshift #(.FFT_LOG2(LOG2), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  exp_t expq[$];
  int   log_i[$];
  int   log_q[$];

  // model state
  bit m_active = 1'b0;
  int m_cnt    = 0;
  int m_bi[NB];
  int m_bq[NB];
  int exp_drops = 0;

  // monitor state
  int  n_drops  = 0;
  int  cur_run  = 0;
  int  max_run  = 0;
  int  sop_run  = 0;
  bit  prev_mid = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Frame-level model: collect bins, emit bin (k + N/2) mod N at output k when complete.
  task automatic model_in(input bit sop, input int i, input int q);
    exp_t e;
    if (sop) begin
      if (m_active && m_cnt != 0) exp_drops++;
      m_active = 1'b1;
      m_cnt    = 0;
    end
    if (m_active) begin
      m_bi[m_cnt] = i;
      m_bq[m_cnt] = q;
      m_cnt++;
      if (m_cnt == NB) begin
        for (int k = 0; k < NB; k++) begin
          e.i   = m_bi[(k + NB / 2) % NB];
          e.q   = m_bq[(k + NB / 2) % NB];
          e.sop = (k == 0);
          e.eop = (k == NB - 1);
          expq.push_back(e);
        end
        m_active = 1'b0;
        m_cnt    = 0;
      end
    end
  endtask

  task automatic send(input bit v, input bit sop, input int i, input int q);
    bus.in_valid = v;
    bus.in_sop   = sop;
    bus.in_i     = DW'(i);
    bus.in_q     = DW'(q);
    @(posedge clk);
    if (v && !rst) model_in(sop, $signed(DW'(i)), $signed(DW'(q)));
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_i     = '0;
    bus.in_q     = '0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < NB; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) send(1'b0, 1'b0, 0, 0);
      end
      send(1'b1, (b == 0), int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, 4095)) - 2048);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", expq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Compare every cycle: valid samples against the model queue, idle cycles must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_mid = 1'b0;
      cur_run  = 0;
      sop_run  = 0;
    end else begin
      if (bus.frame_drop) n_drops++;
      if (bus.out_valid) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        sop_run = bus.out_sop ? 1 : sop_run + 1;
        log_i.push_back(int'(bus.out_i));
        log_q.push_back(int'(bus.out_q));
        chk("out_expected", (expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_i", bus.out_i, e.i);
          chk("out_q", bus.out_q, e.q);
          chk("out_sop", bus.out_sop, e.sop);
          chk("out_eop", bus.out_eop, e.eop);
        end
        if (bus.out_eop) chk("burst_len", sop_run, NB);
        prev_mid = !bus.out_eop;
      end else begin
        cur_run = 0;
        chk("idle_zero", {bus.out_i, bus.out_q, bus.out_sop, bus.out_eop}, 0);
        if (prev_mid) chk("burst_gap", bus.out_valid, 1);
        prev_mid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    int cnt;
    int drops0;
    int exp1[NB];
    exp1 = '{4, 5, 6, 7, 0, 1, 2, 3};

    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_i     = '0;
    bus.in_q     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sop", bus.out_sop, 0);
    chk("rst_out_eop", bus.out_eop, 0);
    chk("rst_frame_drop", bus.frame_drop, 0);
    chk("rst_out_iq", {bus.out_i, bus.out_q}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ramp frame: order, sop/eop placement and latency.
    log_i.delete();
    log_q.delete();
    for (int b = 0; b < NB; b++) send(1'b1, (b == 0), b, -b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk("first_out_latency", lat, 3);
    drain();
    chk("ramp_count", log_i.size(), NB);
    for (int k = 0; k < NB; k++) begin
      if (k < log_i.size()) begin
        chk("ramp_i", log_i[k], exp1[k]);
        chk("ramp_q", log_q[k], -exp1[k]);
      end
    end

    // Back-to-back at full rate.
    max_run = 0;
    drops0  = n_drops;
    for (int f = 0; f < 3; f++) send_frame(1'b0);
    drain();
    chk("b2b_contiguous", max_run, 3 * NB);
    chk("b2b_no_drop", n_drops - drops0, 0);

    // Random input gaps.
    for (int f = 0; f < 3; f++) send_frame(1'b1);
    drain();

    // sop reasserted at wr_cnt = 5.
    drops0 = n_drops;
    for (int b = 0; b < 5; b++) send(1'b1, (b == 0), 100 + b, 200 + b);
    send_frame(1'b0);
    drain();
    chk("drop_pulse", n_drops - drops0, 1);

    // Reset during drain at output sample 3.
    send_frame(1'b0);
    seen = 0;
    cnt  = 0;
    while (seen < 4 && cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (bus.out_valid) seen++;
    end
    chk("reached_sample3", seen, 4);
    rst = 1'b1;
    expq.delete();
    m_active = 1'b0;
    m_cnt    = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_kills_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < NB; b++) send(1'b1, 1'b0, b + 1, b + 1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("no_sop_silent", cnt, 0);
    @(posedge clk);
    #1;
    send_frame(1'b0);
    drain();

    // Full-scale extremes at bins 0 and 4.
    log_i.delete();
    log_q.delete();
    for (int b = 0; b < NB; b++) begin
      if (b == 0)      send(1'b1, 1'b1, -2048, 2047);
      else if (b == 4) send(1'b1, 1'b0, 2047, -2048);
      else             send(1'b1, 1'b0, b * 3, -b * 5);
    end
    drain();
    chk("fs_count", log_i.size(), NB);
    if (log_i.size() == NB) begin
      chk("fs_out0_i", log_i[0], 2047);
      chk("fs_out0_q", log_q[0], -2048);
      chk("fs_out4_i", log_i[4], -2048);
      chk("fs_out4_q", log_q[4], 2047);
    end

    // Randomized soak with gaps and occasional aborted frames.
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, NB - 1)); b++)
          send(1'b1, (b == 0), int'($urandom_range(0, 4095)) - 2048, 7);
      end
      send_frame($urandom_range(0, 1) == 1);
    end
    drain();
    chk("drop_total", n_drops, exp_drops);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_fftshift.md
# rx_fftshift

Receive-side spectrum reorder that sits between the receive FFT core output and the subcarrier demapper. It buffers each FFT output frame of N bins and replays it with the two halves swapped, so DC moves to the centre of the frame. This undoes the transmit-side fs/2 modulation and returns subcarriers in natural order. Ping-pong buffering lets the block accept back-to-back frames at one sample per clock with no backpressure.

## Interface
- FFT_LOG2, 8: log2 of frame length N (N = 2**FFT_LOG2, N ≥ 4).
- DATA_W, 12: signed sample width per rail.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample strobe; gaps allowed.
- in_sop  in  1  qualifies the first bin (bin 0) of a frame; meaningful only with in_valid.
- in_i, in_q  in  DATA_W signed  FFT output bin.
- out_valid  out  1  output sample strobe.
- out_sop  out  1  high with the first output sample of a frame.
- out_eop  out  1  high with the last output sample of a frame.
- out_i, out_q  out  DATA_W signed  reordered bin; 0 when out_valid is low.
- frame_drop  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Storage is 2N words of {i,q}, split into bank 0 and bank 1. The bank select is the address MSB.
- Writer FSM:
  - WAIT_SOP: ignore in_valid samples until in_valid & in_sop. That sample is written at wr_cnt = 0, then go to FILL.
  - FILL: each in_valid writes at wr_cnt and increments it.
  - When the sample at wr_cnt = N-1 is written, the writer toggles wr_bank, issues a read start for the filled bank, clears wr_cnt, and returns to WAIT_SOP.
- in_sop seen in FILL with wr_cnt ≠ 0: abandon the partial frame, pulse frame_drop, and treat that sample as bin 0 of a new frame in the same bank. Data is unchanged.
- Reader FSM:
  - IDLE: on read start, latch rd_bank and go to READ with rd_cnt = 0.
  - READ: each cycle, read address {rd_bank, rd_cnt XOR N/2}, i.e. the MSB of the bin index is inverted; increment rd_cnt.
  - After rd_cnt = N-1, return to IDLE. A read start arriving in that same cycle goes directly to READ with rd_cnt = 0.
- Output order: output k carries input bin (k + N/2) mod N. Examples for N = 8: outputs are 4,5,6,7,0,1,2,3.
- Values pass unchanged: no negation, scaling or saturation. Full-scale −2**(DATA_W−1) is preserved.
- No write/read collision is possible. A frame takes ≥ N cycles to fill and exactly N cycles to drain, so the reader always leaves a bank before the writer re-enters it.

## Timing
- RAM read latency is 1 cycle, and the output register adds 1 cycle.
- The first out_valid (with out_sop) occurs 2 clocks after the edge that captured input bin N−1.
- The output then runs N consecutive cycles of out_valid. out_eop is high on the last of them.
- Back-to-back full-rate input gives continuous out_valid with no gap between frames.
- Reset values: out_valid, out_sop, out_eop, frame_drop, out_i and out_q are all 0. Writer goes to WAIT_SOP, reader to IDLE, wr_bank = 0, counters = 0.
- Reset mid-operation aborts any frame being filled or drained; no further out_valid is produced until a new complete frame arrives.
- RAM contents are not reset and are never output without being rewritten first.

## Structure
- Shared package rx_pkg:
  - FFT_LOG2 / N constants.
  - typedef iq_t (packed struct of signed i, q).
  - Writer and reader state enums.
- Sub-module rx_fftshift_ram: simple dual-port RAM, 2N × 2·DATA_W, one write port and one registered read port with 1-cycle latency, no reset. Inferable as block RAM.
- The top holds both FSMs, the counters, the address XOR and the output register.

## Test plan
- FFT_LOG2 = 3, one frame with in_i = 0..7 and in_q = −0..−7, sop on the first sample. Expect out_i = 4,5,6,7,0,1,2,3 (q negated likewise). out_sop on the 4 entry, out_eop on the 3 entry, first out_valid 2 clocks after input 7.
- Three back-to-back frames at full rate. Expect 24 contiguous out_valid cycles, each frame correctly half-swapped, and no frame_drop.
- Input with random in_valid gaps (50% duty). Expect identical output content, and each frame's output burst to be contiguous for 8 cycles.
- in_sop reasserted at wr_cnt = 5. Expect a frame_drop pulse, no output for the partial frame, and the following full frame output correctly.
- rst asserted mid-drain (output sample 3). Expect out_valid low the next cycle. A subsequent frame presented without sop yields no output; a frame presented with sop outputs normally.
- Values −2048 and 2047 (DATA_W = 12) at bins 0 and 4. Expect −2048 and 2047 to appear unchanged at outputs 4 and 0 respectively.
